// File: rtl/avalon_status_poller.sv
// avalon_status_poller: Avalon-MM read master polling one status word until a masked match, abort or poll budget
module avalon_status_poller #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int POLL_INTERVAL = 16,
  parameter int CNT_W         = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [DATA_W-1:0] cfg_value,
  input  logic [CNT_W-1:0]  cfg_max_polls,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              aborted,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  poll_count
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, CHECK, GAP} state_t;
  localparam int GW = POLL_INTERVAL > 1 ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_INTERVAL > 0 ? POLL_INTERVAL - 1 : 0);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mask_q, mask_d, value_q, value_d, last_q, last_d;
  logic [CNT_W-1:0] max_q, max_d, cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic abort_q, abort_d, read_q, read_d;
  logic done_q, done_d, timeout_q, timeout_d, aborted_q, aborted_d;
  logic accept, cap, ab, match;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    value_d   = value_q;
    max_d     = max_q;
    abort_d   = abort_q;
    read_d    = read_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    aborted_d = 1'b0;
    accept    = state_q == ISSUE && read_q && !avm_waitrequest;
    // a zero-latency slave may return data in the acceptance cycle itself
    cap       = avm_readdatavalid && (state_q == WAIT_DATA || accept);
    last_d    = cap ? avm_readdata : last_q;
    cnt_d     = cap && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    ab        = abort_q || abort;
    match     = ((last_q ^ value_q) & mask_q) == '0;
    case (state_q)
      IDLE: if (start) begin
        addr_d  = cfg_addr;
        mask_d  = cfg_mask;
        value_d = cfg_value;
        max_d   = cfg_max_polls;
        cnt_d   = '0;
        abort_d = 1'b0;
        read_d  = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        abort_d = ab;
        if (accept) begin
          read_d  = 1'b0;
          state_d = cap ? CHECK : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        abort_d = ab;
        state_d = cap ? CHECK : WAIT_DATA;
      end
      CHECK: begin
        abort_d = ab;
        if (match) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (ab) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (max_q != '0 && cnt_q == max_q) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (POLL_INTERVAL == 0) begin
          read_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (ab) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (gap_q == GAP_LAST) begin
          read_d  = 1'b1;
          state_d = ISSUE;
        end else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      value_q   <= '0;
      max_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      abort_q   <= 1'b0;
      read_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      value_q   <= value_d;
      max_q     <= max_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      abort_q   <= abort_d;
      read_q    <= read_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      aborted_q <= aborted_d;
    end
  assign avm_address    = read_q ? addr_q : '0;
  assign avm_read       = read_q;
  assign avm_byteenable = 4'hF;
  assign busy           = state_q != IDLE;
  assign done           = done_q;
  assign timeout        = timeout_q;
  assign aborted        = aborted_q;
  assign last_data      = last_q;
  assign poll_count     = cnt_q;
endmodule

// File: tb/tb_avalon_status_poller.sv
// tb_avalon_status_poller: directed vector bench with a behavioural Avalon slave
module tb_avalon_status_poller;
  localparam int AW = 32, DW = 32, CW = 24, PI = 4;
  logic clk, reset_n, start, abort;
  logic [AW-1:0] cfg_addr, avm_address;
  logic [DW-1:0] cfg_mask, cfg_value, avm_readdata, last_data;
  logic [CW-1:0] cfg_max_polls, poll_count;
  logic avm_read, avm_waitrequest, avm_readdatavalid, busy, done, timeout, aborted;
  logic [3:0] avm_byteenable;
  avalon_status_poller #(.ADDR_W(AW), .DATA_W(DW), .POLL_INTERVAL(PI), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_value(cfg_value), .cfg_max_polls(cfg_max_polls),
    .avm_address(avm_address), .avm_read(avm_read), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
    .last_data(last_data), .poll_count(poll_count));
  initial clk = 0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
    end
  endtask
  bit slave_en = 0;
  int lat = 1, wait_left = 0, pend = 0, reads_n = 0, addr_bad = 0, read_slots = 0, idle = 0, min_idle = 1000;
  bit seen_data = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] def_word = '0;
  logic [DW-1:0] resp_q[$];
  int n_done = 0, n_to = 0, n_ab = 0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (timeout) n_to++;
    if (aborted) n_ab++;
  end
  task automatic deliver();
    avm_readdatavalid = 1;
    avm_readdata = resp_q.size() > 0 ? resp_q.pop_front() : def_word;
    idle = 0;
    seen_data = 1;
  endtask
  initial begin : slave
    forever begin
      @(posedge clk);
      #1;
      if (slave_en) begin
        avm_readdatavalid = 0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) deliver();
        end
        if (avm_read) begin
          read_slots++;
          if (avm_address != exp_addr) addr_bad++;
          if (wait_left > 0) begin
            avm_waitrequest = 1;
            wait_left--;
          end else begin
            avm_waitrequest = 0;
            reads_n++;
            if (seen_data && idle < min_idle) min_idle = idle;
            if (lat == 0) deliver();
            else pend = lat;
          end
        end else begin
          avm_waitrequest = 0;
          if (!avm_readdatavalid) idle++;
        end
      end
    end
  end
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] mask, value;
    logic [CW-1:0] maxp;
    int lat, waits, n_miss;
    logic [DW-1:0] miss_word, hit_word;
    bit exp_done, exp_to;
    int exp_polls;
    logic [DW-1:0] exp_last;
    int exp_rslots;
  } vec_t;
  task automatic setup(input logic [AW-1:0] a, input int l, input int w, input int nm,
                       input logic [DW-1:0] mw, input logic [DW-1:0] hw);
    lat = l; wait_left = w; exp_addr = a; def_word = hw;
    resp_q.delete();
    for (int i = 0; i < nm; i++) resp_q.push_back(mw);
    reads_n = 0; addr_bad = 0; read_slots = 0; idle = 0; min_idle = 1000; seen_data = 0;
    n_done = 0; n_to = 0; n_ab = 0;
  endtask
  task automatic kick(input logic [AW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] v,
                      input logic [CW-1:0] mp, input logic ab);
    @(negedge clk);
    cfg_addr = a; cfg_mask = m; cfg_value = v; cfg_max_polls = mp; start = 1; abort = ab;
    @(negedge clk);
    start = 0; abort = 0;
    cfg_addr = ~a; cfg_mask = '0; cfg_value = ~v; cfg_max_polls = 1;
  endtask
  task automatic wait_end(input string n);
    int cyc = 0;
    while (!(done || timeout || aborted) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({n, "_terminated"}, cyc < 3000, 1);
    chk({n, "_busy_at_pulse"}, busy, 0);
  endtask
  task automatic run(input vec_t v, input string n);
    setup(v.addr, v.lat, v.waits, v.n_miss, v.miss_word, v.hit_word);
    kick(v.addr, v.mask, v.value, v.maxp, 0);
    chk({n, "_busy"}, busy, 1);
    wait_end(n);
    repeat (PI + 8) @(negedge clk);
    chk({n, "_done"}, n_done, v.exp_done);
    chk({n, "_timeout"}, n_to, v.exp_to);
    chk({n, "_aborted"}, n_ab, 0);
    chk({n, "_poll_count"}, poll_count, v.exp_polls);
    chk({n, "_reads"}, reads_n, v.exp_polls);
    chk({n, "_last_data"}, last_data, v.exp_last);
    chk({n, "_addr_bad"}, addr_bad, 0);
    if (v.exp_polls > 1) chk({n, "_gap_ok"}, min_idle >= PI, 1);
    if (v.exp_rslots > 0) chk({n, "_read_slots"}, read_slots, v.exp_rslots);
  endtask
  task automatic abort_seq(input logic [DW-1:0] hw, input bit exp_done, input string n);
    int cyc = 0;
    setup(32'h800, 4, 0, 0, 0, hw);
    kick(32'h800, 32'h1, 32'h1, 0, 0);
    while (reads_n == 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({n, "_read_seen"}, reads_n, 1);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_end(n);
    repeat (20) @(negedge clk);
    chk({n, "_done"}, n_done, exp_done);
    chk({n, "_aborted"}, n_ab, !exp_done);
    chk({n, "_reads"}, reads_n, 1);
    chk({n, "_poll_count"}, poll_count, 1);
  endtask
  vec_t vt[7];
  initial begin
    vt[0] = '{32'h100, 32'h1, 32'h1, 0, 1, 0, 0, 0, 32'h1, 1, 0, 1, 32'h1, 1};
    vt[1] = '{32'h200, 32'h1, 32'h1, 0, 1, 0, 3, 0, 32'h1, 1, 0, 4, 32'h1, 0};
    vt[2] = '{32'h300, 32'h1, 32'h1, 5, 1, 0, 0, 0, 32'h0, 0, 1, 5, 32'h0, 0};
    vt[3] = '{32'h400, 32'hF0, 32'hA0, 0, 2, 3, 0, 0, 32'hA5, 1, 0, 1, 32'hA5, 4};
    vt[4] = '{32'h500, 32'h0, 32'hFFFF, 0, 1, 0, 0, 0, 32'h1234, 1, 0, 1, 32'h1234, 0};
    vt[5] = '{32'h600, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 3, 0, 0, 2, 32'hDEAD_BEEE, 32'hDEAD_BEEF, 1, 0, 3, 32'hDEAD_BEEF, 0};
    vt[6] = '{32'h700, 32'h1, 32'h1, 1, 2, 0, 0, 0, 32'h0, 0, 1, 1, 32'h0, 0};
    reset_n = 0; start = 0; abort = 0;
    cfg_addr = '0; cfg_mask = '0; cfg_value = '0; cfg_max_polls = '0;
    avm_waitrequest = 0; avm_readdata = '0; avm_readdatavalid = 0;
    repeat (3) @(negedge clk);
    chk("rst_read", avm_read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {done, timeout, aborted}, 0);
    chk("rst_count", poll_count, 0);
    reset_n = 1;
    slave_en = 1;
    for (int i = 0; i < 7; i++) run(vt[i], $sformatf("vec%0d", i));
    abort_seq(32'h0, 0, "abort_miss");
    abort_seq(32'h1, 1, "abort_hit");
    n_ab = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_pulse", n_ab, 0);
    vt[0].addr = 32'h900;
    setup(32'h900, 1, 0, 0, 0, 32'h1);
    kick(32'h900, 32'h1, 32'h1, 0, 1);
    wait_end("start_abort");
    repeat (3) @(negedge clk);
    chk("start_abort_done", n_done, 1);
    chk("start_abort_aborted", n_ab, 0);
    slave_en = 0;
    avm_waitrequest = 1;
    avm_readdatavalid = 0;
    kick(32'hA00, 32'h1, 32'h1, 0, 0);
    @(negedge clk);
    chk("midrst_read_before", avm_read, 1);
    #2 reset_n = 0;
    #1;
    chk("midrst_read", avm_read, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", poll_count, 0);
    chk("midrst_last", last_data, 0);
    @(negedge clk);
    reset_n = 1;
    avm_waitrequest = 0;
    avm_readdata = 32'h55;
    avm_readdatavalid = 1;
    @(negedge clk);
    avm_readdatavalid = 0;
    repeat (2) @(negedge clk);
    chk("stray_last", last_data, 0);
    chk("stray_count", poll_count, 0);
    chk("stray_busy", busy, 0);
    slave_en = 1;
    pend = 0;
    run(vt[0], "after_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/avalon_status_poller.md
Name: avalon_status_poller

Overview:
- Avalon-MM read master that repeatedly reads one status register, such as a 32-bit single-bit-input PIO done flag, until a masked compare matches or a poll budget runs out.
- Sits on the FPGA fabric side of the interconnect.
- Lets accelerator control logic wait on a status slave without HPS involvement.
- Reports completion, timeout, the last read word and the number of polls issued.

Parameters:
- ADDR_W, 32, width of avm_address and cfg_addr
- DATA_W, 32, width of avm_readdata, cfg_mask, cfg_value, last_data
- POLL_INTERVAL, 16, idle cycles between one read's data return and the next read issue; 0 means back-to-back
- CNT_W, 24, width of cfg_max_polls and poll_count

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin polling; ignored while busy
- abort  in  1  one-cycle request to stop polling
- cfg_addr  in  ADDR_W  byte address of status register
- cfg_mask  in  DATA_W  bits participating in compare
- cfg_value  in  DATA_W  expected value of masked bits
- cfg_max_polls  in  CNT_W  poll budget; 0 = unlimited
- avm_address  out  ADDR_W  read address
- avm_read  out  1  read request
- avm_byteenable  out  4  constant 4'hF
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data valid
- busy  out  1  high from the cycle after accepted start until the cycle after termination
- done  out  1  one-cycle pulse on match
- timeout  out  1  one-cycle pulse when budget exhausted
- aborted  out  1  one-cycle pulse when terminated by abort
- last_data  out  DATA_W  most recent readdata captured
- poll_count  out  CNT_W  reads completed in current or last session

Behaviour:
- Reset: clk and reset_n as already decided. All outputs are 0 and the state is IDLE. Reset mid-transaction drops avm_read immediately, and any readdatavalid arriving after reset is ignored.
- Start and configuration:
  - On start in IDLE, latch cfg_addr, cfg_mask, cfg_value and cfg_max_polls.
  - Clear poll_count and the abort latch, then go to ISSUE.
  - Configuration changes during a session have no effect.
- States: IDLE, ISSUE, WAIT_DATA, CHECK, GAP.
- ISSUE:
  - avm_read=1 and avm_address=latched address, both registered outputs.
  - Hold avm_read and address stable while avm_waitrequest=1.
  - The read is accepted in the first cycle with avm_read=1 and avm_waitrequest=0. In that cycle go to WAIT_DATA, and deassert avm_read the next cycle.
  - At most one read is ever outstanding.
- WAIT_DATA:
  - On avm_readdatavalid, capture last_data, increment poll_count, then go to CHECK.
  - readdatavalid in any other state is ignored.
  - A readdatavalid in the same cycle as acceptance (zero-latency slave) is legal and must be captured.
- CHECK (one cycle), priority high to low:
  - Match, defined as (last_data & mask) == (value & mask): pulse done, go to IDLE.
  - Abort latched: pulse aborted, go to IDLE.
  - max_polls != 0 and poll_count == max_polls: pulse timeout, go to IDLE.
  - Otherwise go to GAP.
- Match with mask=0 succeeds on the first read.
- GAP:
  - Counts POLL_INTERVAL cycles, then goes to ISSUE. POLL_INTERVAL=0 goes straight to ISSUE.
  - Abort seen in GAP, or latched: pulse aborted the next cycle, go to IDLE.
- Abort handling:
  - Abort asserted in ISSUE or WAIT_DATA is latched. The in-flight Avalon read is never withdrawn; the session terminates at CHECK after data returns.
  - Abort in IDLE is ignored.
  - start and abort in the same cycle in IDLE: start wins, abort ignored.
- poll_count saturates at all-ones; it does not wrap.
- last_data and poll_count hold their values after termination until the next accepted start.
- busy falls in the same cycle the done, timeout or aborted pulse is asserted.
- Latency: with zero waitrequest and read latency L, one poll period is 1 (issue) + L + 1 (CHECK) + POLL_INTERVAL cycles.

Test Plan:
- Immediate match:
  - Stimulus: addr=0x100, mask=0x1, value=0x1, slave returns 0x1 with latency 1, no waitrequest.
  - Response: one read at 0x100, done pulse, poll_count=1, last_data=0x1, busy low afterwards.
- Delayed match:
  - Stimulus: slave returns 0x0 three times then 0x1, POLL_INTERVAL=4, max_polls=0.
  - Response: four reads, at least 4 idle cycles between data return and next avm_read, done after 4th read, poll_count=4.
- Timeout:
  - Stimulus: slave always returns 0x0, max_polls=5.
  - Response: exactly 5 reads, timeout pulse, no done pulse, poll_count=5.
- Waitrequest hold:
  - Stimulus: waitrequest high for 3 cycles on the first read.
  - Response: avm_read and avm_address stable for all 4 cycles, single acceptance, no duplicate read.
- Abort mid-read:
  - Stimulus: abort during WAIT_DATA with slave returning 0x0.
  - Response: read completes, aborted pulse at CHECK, no further reads.
  - Stimulus: repeat with slave returning 0x1.
  - Response: done has priority over aborted.
- Reset mid-transaction:
  - Stimulus: reset_n low while avm_read=1, then a stray readdatavalid after release.
  - Response: all outputs 0, state IDLE, stray data ignored, next start works normally.
